board_led_driver: RTL and testbench
===================================

Name: board_led_driver

Overview:
Downstream consumer of the board LED PIO output port. Takes the 4-bit LED pattern written by software and drives the physical LED pins. Adds global PWM dimming, per-LED blink, and a power-up lamp test. Sits between the LED PIO and the top-level LED pins.

Parameters:
N_LEDS, 4, number of LEDs; width of led_in, blink_en and led_out.
PWM_WIDTH, 8, width of the PWM counter and of brightness.
BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 1.
LAMP_TEST_CYCLES, 50000000, length of the post-reset all-on lamp test; 0 disables the lamp test.
ACTIVE_LOW, 1, 1 means LED pins are lit at logic 0.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  asynchronous reset, active-high.
led_in  in  N_LEDS  LED pattern from the PIO out_port; 1 = LED enabled.
blink_en  in  N_LEDS  per-LED blink enable.
brightness  in  PWM_WIDTH  global duty value; all-ones means 100 %.
led_out  out  N_LEDS  LED pin drive; polarity set by ACTIVE_LOW.
lamp_test_active  out  1  high while the lamp test runs.
pwm_sync  out  1  one-cycle pulse at each PWM period wrap.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - led_out = off level (all ones if ACTIVE_LOW, else all zeros).
  - lamp_test_active = 1.
  - pwm_sync = 0.
  - All counters = 0; blink_phase = 1; bright_eff = 0; FSM = S_LAMP.
- Asserting reset mid-operation aborts immediately. The lamp test restarts on release.
- Input stage: led_in, blink_en and brightness are registered every cycle. Latency from input to led_out is 2 cycles (input register, then output register).
- PWM:
  - pwm_cnt increments every cycle and wraps from 2^PWM_WIDTH-1 to 0.
  - pwm_sync is registered and equals 1 in the cycle after pwm_cnt == 2^PWM_WIDTH-1.
  - bright_eff loads brightness_r only when pwm_cnt == max, so a change takes effect at the next period. There are no mid-period glitches.
  - pwm_on = (bright_eff == all-ones) OR (pwm_cnt < bright_eff). Brightness 0 is never lit. All-ones is constantly lit.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1 and is held at 0 in S_LAMP.
  - At terminal count, blink_cnt clears and blink_phase toggles.
  - blink_phase = 1 means lit.
- FSM:
  - S_LAMP: lamp_cnt counts 0..LAMP_TEST_CYCLES-1. All LEDs are lit at 100 %, ignoring all inputs. lamp_test_active = 1. At lamp_cnt == LAMP_TEST_CYCLES-1, go to S_RUN.
  - If LAMP_TEST_CYCLES == 0, go to S_RUN on the first cycle after reset release.
  - S_RUN: lamp_test_active = 0. lit[i] = led_in_r[i] & (~blink_en_r[i] | blink_phase) & pwm_on.
  - S_RUN is left only by reset.
- Output: led_out is registered as ACTIVE_LOW ? ~lit : lit.
- pwm_cnt free-runs in both states, so pwm_sync pulses during the lamp test too.

Optional Feature:
Macro: BOARD_LED_DRIVER_FADE_EN.
- Defined: at each PWM wrap, bright_eff steps by exactly 1 toward brightness_r (+1 if less, -1 if greater, unchanged if equal). Brightness changes therefore ramp over |delta| PWM periods.
- Not defined: bright_eff loads brightness_r directly at the wrap (single-step jump).
- The lamp test is identical in both builds.

Test Plan:
Bench parameters for all scenarios: N_LEDS=4, PWM_WIDTH=4, BLINK_DIV=4, LAMP_TEST_CYCLES=10, ACTIVE_LOW=1.
1. Hold reset, led_in=0 → led_out=4'hF, lamp_test_active=1. Release reset → led_out=4'h0 from cycle 1 for 10 cycles, then lamp_test_active=0 and led_out=4'hF.
2. After lamp test: led_in=4'b0101, brightness=4'hF, blink_en=0 → led_out=4'b1010 constant. Changing led_in to 4'b0011 gives led_out=4'b1100 exactly 2 cycles later.
3. brightness=4, led_in=4'hF → each LED lit (0) for 4 of every 16 cycles, aligned to the pwm_sync period. pwm_sync pulses every 16 cycles.
4. brightness changed mid-period from 4 to 12 → the old duty persists until the wrap, then 12/16 duty. brightness=0 → led_out=4'hF permanently.
5. blink_en=4'b0001, led_in=4'hF, brightness=4'hF → LED0 toggles every 4 cycles, starting lit on S_RUN entry. LEDs 1-3 stay steady lit. Reset mid-blink → lamp test restarts and blink_phase=1.
6. With BOARD_LED_DRIVER_FADE_EN, brightness 0→3 → duty 1/16, 2/16, 3/16 over three successive periods. Without the macro → 3/16 from the first wrap.

Source files
------------

// File: rtl/board_led_driver.sv
// board_led_driver: drives the physical board LEDs from the LED PIO pattern.
// Adds global PWM dimming, per-LED blink and a power-up lamp test.
// Optional feature macro: BOARD_LED_DRIVER_FADE_EN. When defined, the
// effective brightness steps by one count per PWM period toward the
// requested value instead of jumping straight to it.
module board_led_driver #(
  parameter int N_LEDS           = 4,
  parameter int PWM_WIDTH        = 8,
  parameter int BLINK_DIV        = 25000000,
  parameter int LAMP_TEST_CYCLES = 50000000,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LEDS-1:0]    led_in,
  input  logic [N_LEDS-1:0]    blink_en,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic [N_LEDS-1:0]    led_out,
  output logic                 lamp_test_active,
  output logic                 pwm_sync
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int LAMP_W  = (LAMP_TEST_CYCLES > 1) ? $clog2(LAMP_TEST_CYCLES) : 1;

  localparam logic [PWM_WIDTH-1:0] PWM_MAX    = {PWM_WIDTH{1'b1}};
  localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [LAMP_W-1:0]    LAMP_LAST  =
    LAMP_W'((LAMP_TEST_CYCLES > 0) ? (LAMP_TEST_CYCLES - 1) : 0);
  // Pin level that leaves every LED dark.
  localparam logic [N_LEDS-1:0]    OFF_LEVEL  = {N_LEDS{ACTIVE_LOW != 0}};

  typedef enum logic [0:0] {
    S_LAMP = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [N_LEDS-1:0]    led_in_r;
  logic [N_LEDS-1:0]    blink_en_r;
  logic [PWM_WIDTH-1:0] brightness_r;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] bright_eff;
  logic [PWM_WIDTH-1:0] bright_next;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [LAMP_W-1:0]    lamp_cnt;
  logic                 pwm_wrap;
  logic                 pwm_on;
  logic                 lamp_on;
  logic [N_LEDS-1:0]    lit;

  // Next effective brightness, applied only at the PWM wrap.
  always_comb begin
    bright_next = bright_eff;
`ifdef BOARD_LED_DRIVER_FADE_EN
    if (bright_eff < brightness_r) begin
      bright_next = bright_eff + PWM_WIDTH'(1);
    end else if (bright_eff > brightness_r) begin
      bright_next = bright_eff - PWM_WIDTH'(1);
    end else begin
      bright_next = bright_eff;
    end
`else
    bright_next = brightness_r;
`endif
  end

  // PWM comparator, lamp-test override and per-LED lit decision.
  always_comb begin
    pwm_wrap = (pwm_cnt == PWM_MAX);
    // All-ones brightness is a steady 100 % with no dark slot per period.
    pwm_on   = (bright_eff == PWM_MAX) || (pwm_cnt < bright_eff);
    // A zero-length lamp test never forces the LEDs on.
    lamp_on  = (state == S_LAMP) && (LAMP_TEST_CYCLES != 0);
    lit      = {N_LEDS{1'b0}};
    if (lamp_on) begin
      lit = {N_LEDS{1'b1}};
    end else begin
      lit = led_in_r & (~blink_en_r | {N_LEDS{blink_phase}}) & {N_LEDS{pwm_on}};
    end
  end

  // Input stage: sample the PIO pattern and controls every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_in_r     <= {N_LEDS{1'b0}};
      blink_en_r   <= {N_LEDS{1'b0}};
      brightness_r <= {PWM_WIDTH{1'b0}};
    end else begin
      led_in_r     <= led_in;
      blink_en_r   <= blink_en;
      brightness_r <= brightness;
    end
  end

  // Free-running PWM counter, wrap pulse and period-aligned brightness update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt    <= {PWM_WIDTH{1'b0}};
      pwm_sync   <= 1'b0;
      bright_eff <= {PWM_WIDTH{1'b0}};
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_WIDTH'(1);
      pwm_sync <= pwm_wrap;
      if (pwm_wrap) begin
        bright_eff <= bright_next;
      end else begin
        bright_eff <= bright_eff;
      end
    end
  end

  // Lamp-test / run sequencer with the blink timebase and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_LAMP;
      lamp_cnt         <= {LAMP_W{1'b0}};
      blink_cnt        <= {BLINK_W{1'b0}};
      blink_phase      <= 1'b1;
      led_out          <= OFF_LEVEL;
      lamp_test_active <= 1'b1;
    end else begin
      case (state)
        S_LAMP: begin
          blink_cnt <= {BLINK_W{1'b0}};
          if ((LAMP_TEST_CYCLES == 0) || (lamp_cnt == LAMP_LAST)) begin
            state <= S_RUN;
          end else begin
            lamp_cnt <= lamp_cnt + LAMP_W'(1);
          end
        end
        S_RUN: begin
          // Only reset leaves S_RUN; the blink timebase runs from entry.
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= {BLINK_W{1'b0}};
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        default: begin
          state <= S_LAMP;
        end
      endcase
      led_out          <= (ACTIVE_LOW != 0) ? ~lit : lit;
      lamp_test_active <= lamp_on;
    end
  end

endmodule

// File: tb/tb_board_led_driver.sv
// Self-checking bench for board_led_driver (N_LEDS=4, PWM_WIDTH=4,
// BLINK_DIV=4, LAMP_TEST_CYCLES=10, ACTIVE_LOW=1). A behavioural model pushes
// the expected {led_out, lamp_test_active, pwm_sync} for every clock edge into
// a queue; scenario tasks pop and compare on the falling edge, and add
// directly stated pattern/duty checks.
module tb_board_led_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led_in = 4'h0;
  logic [3:0] blink_en = 4'h0;
  logic [3:0] brightness = 4'h0;
  logic [3:0] led_out;
  logic       lamp_test_active;
  logic       pwm_sync;

  logic [5:0] obs;
  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  assign obs = {led_out, lamp_test_active, pwm_sync};

  board_led_driver #(
    .N_LEDS(4), .PWM_WIDTH(4), .BLINK_DIV(4), .LAMP_TEST_CYCLES(10), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .led_in(led_in), .blink_en(blink_en),
    .brightness(brightness), .led_out(led_out),
    .lamp_test_active(lamp_test_active), .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit         m_run = 1'b0;
  bit         m_phase = 1'b1;
  int         m_lamp = 0;
  int         m_pwm = 0;
  int         m_eff = 0;
  int         m_blink = 0;
  int         m_bri = 0;
  logic [3:0] m_led = 4'h0;
  logic [3:0] m_blk = 4'h0;

  initial begin
    bit         on;
    logic [3:0] lit;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_run = 1'b0; m_phase = 1'b1; m_lamp = 0; m_pwm = 0; m_eff = 0;
        m_blink = 0; m_bri = 0; m_led = 4'h0; m_blk = 4'h0;
      end else begin
        on = (m_eff == 15) || (m_pwm < m_eff);
        if (!m_run) lit = 4'hF;
        else        lit = m_led & (~m_blk | {4{m_phase}}) & {4{on}};
        exp_q.push_back({~lit, !m_run, (m_pwm == 15)});
        if (m_pwm == 15) begin
`ifdef BOARD_LED_DRIVER_FADE_EN
          if (m_eff < m_bri) m_eff++;
          else if (m_eff > m_bri) m_eff--;
`else
          m_eff = m_bri;
`endif
        end
        m_pwm = (m_pwm + 1) % 16;
        if (!m_run) begin
          m_blink = 0;
          if (m_lamp == 9) m_run = 1'b1;
          else m_lamp++;
        end else if (m_blink == 3) begin
          m_blink = 0;
          m_phase = !m_phase;
        end else begin
          m_blink++;
        end
        m_led = led_in; m_blk = blink_en; m_bri = brightness;
      end
    end
  end

  // Advance to the next falling edge and fetch the model's expectation.
  task automatic next_exp(output logic [5:0] e, output bit ok);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ok = 1'b1;
    end else begin
      e = 6'b0; ok = 1'b0;
    end
  endtask

  // Wait (bounded) for a pwm_sync pulse, discarding model entries meanwhile.
  task automatic wait_sync(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      exp_q.delete();
      if (pwm_sync === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [5:0] e; bit ok;
    reset = 1'b1; led_in = 4'h0; blink_en = 4'h0; brightness = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 6'b1111_1_0) begin
      n_bad++; $display("FAIL reset_hold: got %b want 111110", obs);
    end
    reset = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 10; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL lamp_model[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
      n_cmp++;
      if (led_out !== 4'h0 || lamp_test_active !== 1'b1) begin
        n_bad++; $display("FAIL lamp_on[%0d]: got led_out=%h lta=%b want 0/1", i, led_out, lamp_test_active);
      end
    end
    next_exp(e, ok);
    n_cmp++;
    if (!ok || obs !== e) begin n_bad++; $display("FAIL lamp_end_model: got %b want %b ok=%0d", obs, e, ok); end
    n_cmp++;
    if (led_out !== 4'hF || lamp_test_active !== 1'b0) begin
      n_bad++; $display("FAIL lamp_end: got led_out=%h lta=%b want F/0", led_out, lamp_test_active);
    end
  endtask

  task automatic test_pattern();
    logic [5:0] e; bit ok;
    led_in = 4'b0101; brightness = 4'hF; blink_en = 4'h0;
    for (int i = 0; i < 272; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL pattern_settle[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
    end
    for (int i = 0; i < 6; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL pattern_model: got %b want %b ok=%0d", obs, e, ok); end
      n_cmp++;
      if (led_out !== 4'b1010) begin n_bad++; $display("FAIL pattern_0101: got %b want 1010", led_out); end
    end
    led_in = 4'b0011;
    next_exp(e, ok);
    n_cmp++;
    if (led_out !== 4'b1010) begin n_bad++; $display("FAIL latency_1: got %b want 1010", led_out); end
    next_exp(e, ok);
    n_cmp++;
    if (led_out !== 4'b1100) begin n_bad++; $display("FAIL latency_2: got %b want 1100", led_out); end
    n_cmp++;
    if (!ok || obs !== e) begin n_bad++; $display("FAIL latency_model: got %b want %b ok=%0d", obs, e, ok); end
  endtask

  task automatic test_pwm();
    logic [5:0] e; bit ok; bit found;
    led_in = 4'hF; brightness = 4'd4;
    for (int i = 0; i < 272; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL pwm_settle[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
    end
    wait_sync(found);
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL pwm_sync_timeout: got no pulse want pulse within 40 cycles"); end
    for (int i = 1; i <= 16; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL pwm_model[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
      n_cmp++;
      if (led_out !== ((i <= 4) ? 4'h0 : 4'hF) || pwm_sync !== (i == 16)) begin
        n_bad++; $display("FAIL pwm_duty4[%0d]: got led_out=%h sync=%b", i, led_out, pwm_sync);
      end
    end
  endtask

  task automatic test_brightness_change();
    logic [5:0] e; bit ok;
`ifdef BOARD_LED_DRIVER_FADE_EN
    int duty2 = 5;
`else
    int duty2 = 12;
`endif
    for (int i = 1; i <= 32; i++) begin
      if (i == 6) brightness = 4'd12;
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL change_model[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
      n_cmp++;
      if (led_out !== (((i <= 16) ? (i <= 4) : ((i - 16) <= duty2)) ? 4'h0 : 4'hF)) begin
        n_bad++; $display("FAIL change_duty[%0d]: got %h", i, led_out);
      end
    end
    brightness = 4'd0;
    for (int i = 0; i < 224; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL zero_settle[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
    end
    for (int i = 0; i < 16; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (led_out !== 4'hF) begin n_bad++; $display("FAIL brightness_zero[%0d]: got %h want F", i, led_out); end
    end
  endtask

  task automatic test_fade();
    logic [5:0] e; bit ok; bit found;
    int cnt[3];
    int want[3];
`ifdef BOARD_LED_DRIVER_FADE_EN
    want = '{1, 2, 3};
`else
    want = '{3, 3, 3};
`endif
    cnt = '{0, 0, 0};
    wait_sync(found);
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL fade_sync_timeout: got no pulse want pulse"); end
    brightness = 4'd3;
    for (int i = 1; i <= 64; i++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL fade_model[%0d]: got %b want %b ok=%0d", i, obs, e, ok); end
      if (i > 16 && led_out === 4'h0) cnt[(i - 17) / 16]++;
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (cnt[k] != want[k]) begin n_bad++; $display("FAIL fade_period%0d: got %0d/16 want %0d/16", k, cnt[k], want[k]); end
    end
  endtask

  // One reset release followed by lamp test and the start of blinking.
  task automatic blink_window(string tag);
    logic [5:0] e; bit ok;
    logic [3:0] want;
    for (int k = 1; k <= 30; k++) begin
      next_exp(e, ok);
      n_cmp++;
      if (!ok || obs !== e) begin n_bad++; $display("FAIL %s_model[%0d]: got %b want %b ok=%0d", tag, k, obs, e, ok); end
      if (k <= 10)      want = 4'h0;
      else if (k <= 16) want = 4'hF;
      else              want = ((((k - 11) / 4) % 2) == 0) ? 4'b0000 : 4'b0001;
`ifdef BOARD_LED_DRIVER_FADE_EN
      if (k <= 16) begin
`endif
      n_cmp++;
      if (led_out !== want) begin n_bad++; $display("FAIL %s_pattern[%0d]: got %b want %b", tag, k, led_out, want); end
`ifdef BOARD_LED_DRIVER_FADE_EN
      end
`endif
    end
  endtask

  task automatic test_blink();
    reset = 1'b1; led_in = 4'hF; brightness = 4'hF; blink_en = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    blink_window("blink");
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 6'b1111_1_0) begin n_bad++; $display("FAIL async_abort: got %b want 111110", obs); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    blink_window("reblink");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_pwm();
    test_brightness_change();
    test_fade();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
